mem_responder: RTL and testbench

//  Memory-side responder for the single-port mem_req/mem_write/mem_addr/mem_wdata ->
//  mem_rdata_vld/mem_rdata interface driven by the matmul engines. Holds a local word array,

---
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder.sv | 153 +++++++++++++++
 tb/tb_mem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - single-port memory request/response bundle between an initiator and mem_responder
interface mem_responder_if #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32
);
  logic              mem_req;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [MEM_DW-1:0] mem_wdata;
  logic              mem_rdata_vld;
  logic [MEM_DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_write, mem_addr, mem_wdata,
    input  mem_rdata_vld, mem_rdata
  );

  modport slave (
    input  mem_req, mem_write, mem_addr, mem_wdata,
    output mem_rdata_vld, mem_rdata
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - scratch word memory answering reads in order after RD_LAT cycles
// Optional MEM_RESP_STALL_EN adds an LFSR-throttled response FIFO for variable read latency.
module mem_responder #(
  parameter int MEM_AW     = 16,
  parameter int MEM_DW     = 32,
  parameter int DEPTH_AW   = 10,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus,
  output logic            oob_err,
  output logic            ovf_err,
  output logic [15:0]     rd_cnt,
  output logic [15:0]     wr_cnt
);

  localparam int DEPTH = 1 << DEPTH_AW;

  logic [MEM_DW-1:0]   mem_array [DEPTH];
  logic                in_range;
  logic [DEPTH_AW-1:0] word_idx;
  logic                wr_en;
  logic                rd_acc;
  logic [MEM_DW-1:0]   rd_word;

  logic [RD_LAT-1:0]   pipe_vld;
  logic [MEM_DW-1:0]   pipe_data [RD_LAT];

  assign in_range = (bus.mem_addr[MEM_AW-1:DEPTH_AW] == '0);
  assign word_idx = bus.mem_addr[DEPTH_AW-1:0];
  assign wr_en    = bus.mem_req & bus.mem_write & in_range;
  assign rd_acc   = bus.mem_req & ~bus.mem_write;
  // Out-of-range reads still respond, with zero data.
  assign rd_word  = in_range ? mem_array[word_idx] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[word_idx] <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= rd_acc;
      pipe_data[0] <= rd_acc ? rd_word : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      oob_err <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else if (bus.mem_req) begin
      if (!in_range) begin
        oob_err <= 1'b1;
      end
      if (bus.mem_write) begin
        wr_cnt <= wr_cnt + 16'd1;
      end else begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end

`ifdef MEM_RESP_STALL_EN

  localparam int              FAW    = $clog2(FIFO_DEPTH);
  localparam logic [FAW:0]    FULL   = (FAW+1)'(FIFO_DEPTH);
  localparam logic [FAW:0]    THRESH = (FAW+1)'(FIFO_DEPTH - 2);

  logic [MEM_DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [FAW-1:0]    wr_ptr;
  logic [FAW-1:0]    rd_ptr;
  logic [FAW:0]      count;
  logic [7:0]        lfsr;

  logic              arrive;
  logic [MEM_DW-1:0] arr_data;
  logic              pop;
  logic              bypass;
  logic              push;
  logic              drop;
  logic              fifo_pop;
  logic [MEM_DW-1:0] head;

  assign arrive   = pipe_vld[RD_LAT-1];
  assign arr_data = pipe_data[RD_LAT-1];

  // An arriving response counts as occupancy so it can leave in the cycle it shows up.
  // Forcing a pop near full keeps the stall bounded and the FIFO from overflowing.
  assign pop      = ((count != '0) || arrive) && (!lfsr[0] || (count >= THRESH));
  assign bypass   = pop && (count == '0);
  assign fifo_pop = pop && !bypass;
  assign push     = arrive && !bypass && ((count != FULL) || pop);
  assign drop     = arrive && (count == FULL) && !pop;
  assign head     = (count == '0) ? arr_data : fifo_mem[rd_ptr];

  assign bus.mem_rdata_vld = pop;
  assign bus.mem_rdata     = pop ? head : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= arr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      lfsr    <= 8'hA5;
      ovf_err <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        ovf_err <= 1'b1;
      end
    end
  end

`else

  assign bus.mem_rdata_vld = pipe_vld[RD_LAT-1];
  assign bus.mem_rdata     = pipe_vld[RD_LAT-1] ? pipe_data[RD_LAT-1] : '0;
  assign ovf_err           = 1'b0;

`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed plus randomized bench for mem_responder against a word-array model
module tb_mem_responder;
  localparam int MEM_AW   = 16;
  localparam int MEM_DW   = 32;
  localparam int DEPTH_AW = 10;
  localparam int RD_LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        oob_err;
  logic        ovf_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  always #5 clk = ~clk;

  mem_responder_if #(.MEM_AW(MEM_AW), .MEM_DW(MEM_DW)) bus ();

  mem_responder #(
    .MEM_AW(MEM_AW), .MEM_DW(MEM_DW), .DEPTH_AW(DEPTH_AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .oob_err(oob_err), .ovf_err(ovf_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  typedef struct {
    logic [31:0] data;
    int          issue;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model[int];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] rd_exp = 0;
  logic [15:0] wr_exp = 0;
  logic        oob_exp = 0;
  logic [31:0] mat_a[2][3];
  logic [31:0] mat_b[3][2];
  logic [31:0] mat_c[2][2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic op(input bit req, input bit wr, input logic [15:0] addr, input logic [31:0] data);
    bit   inr;
    exp_t e;
    @(posedge clk);
    #1;
    bus.mem_req   = req;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    inr = (addr[15:10] == 6'd0);
    if (req) begin
      if (!inr) oob_exp = 1'b1;
      if (wr) begin
        wr_exp++;
        if (inr) model[int'(addr[9:0])] = data;
      end else begin
        rd_exp++;
        e.data  = inr ? model[int'(addr[9:0])] : 32'd0;
        e.issue = cyc;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 1'b0, 16'd0, 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.mem_rdata_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_vld", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rdata", bus.mem_rdata, e.data);
`ifdef MEM_RESP_STALL_EN
        check("latency_min", 32'((cyc - e.issue) >= RD_LAT), 32'd1);
`else
        check("latency", cyc - e.issue, RD_LAT);
`endif
      end
    end else if (rst_n) begin
      check("rdata_idle", bus.mem_rdata, 32'd0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin : stim
    bus.mem_req = 0; bus.mem_write = 0; bus.mem_addr = 0; bus.mem_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", bus.mem_rdata_vld, 0);
    check("rst_rdata", bus.mem_rdata, 0);
    check("rst_oob", oob_err, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_rd_cnt", rd_cnt, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // write then immediate read of the same word
    op(1, 1, 16'h0005, 32'h11223344);
    op(1, 0, 16'h0005, 0);
    idle(4);

    // sequential writes and back-to-back reads
    for (int i = 0; i < 8; i++) op(1, 1, 16'(i), 32'(i * 3));
    for (int i = 0; i < 8; i++) op(1, 0, 16'(i), 0);
    idle(20);
    check("t2_rd_cnt", rd_cnt, rd_exp);
    check("t2_wr_cnt", wr_cnt, wr_exp);

    // out-of-range accesses
    op(1, 0, 16'h0400, 0);
    idle(20);
    check("t3_oob_rd", oob_err, 1);
    op(1, 1, 16'hFC00, 32'hDEADBEEF);
    op(1, 0, 16'h0000, 0);
    idle(20);
    check("t3_oob_sticky", oob_err, 1);
    check("t3_rd_cnt", rd_cnt, rd_exp);
    check("t3_wr_cnt", wr_cnt, wr_exp);

    // reset with reads in flight
    op(1, 1, 16'h0020, 32'hCAFEF00D);
    idle(20);
    op(1, 0, 16'h0020, 0);
    op(1, 0, 16'h0020, 0);
    @(posedge clk);
    #1;
    bus.mem_req = 0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    rd_exp = 0; wr_exp = 0; oob_exp = 0;
    check("t4_vld", bus.mem_rdata_vld, 0);
    check("t4_rdata", bus.mem_rdata, 0);
    check("t4_oob", oob_err, 0);
    check("t4_ovf", ovf_err, 0);
    check("t4_rd_cnt", rd_cnt, 0);
    check("t4_wr_cnt", wr_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(8);
    op(1, 0, 16'h0020, 0);
    idle(20);

    // randomized mix over a preloaded region
    for (int i = 0; i < 16; i++) op(1, 1, 16'(16'h0040 + i), $urandom);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle(1);
      end else if ($urandom_range(0, 15) == 0) begin
        op(1, 1'($urandom_range(0, 1)), 16'(16'h0800 | $urandom_range(0, 63)), $urandom);
      end else begin
        op(1, 1'($urandom_range(0, 1)), 16'(16'h0040 + $urandom_range(0, 15)), $urandom);
      end
    end
    idle(40);
    check("t5_ovf", ovf_err, 0);
    check("t5_oob", oob_err, oob_exp);
    check("t5_rd_cnt", rd_cnt, rd_exp);
    check("t5_wr_cnt", wr_cnt, wr_exp);

    // 2x3 * 3x2 product staged through the memory
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) begin
        mat_a[i][k] = $urandom_range(0, 255);
        op(1, 1, 16'(16'h0100 + i * 3 + k), mat_a[i][k]);
      end
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 2; j++) begin
        mat_b[k][j] = $urandom_range(0, 255);
        op(1, 1, 16'(16'h0110 + k * 2 + j), mat_b[k][j]);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        mat_c[i][j] = 0;
        for (int k = 0; k < 3; k++) mat_c[i][j] += mat_a[i][k] * mat_b[k][j];
        op(1, 1, 16'(16'h0120 + i * 2 + j), mat_c[i][j]);
      end
    for (int a = 0; a < 6; a++) op(1, 0, 16'(16'h0100 + a), 0);
    for (int a = 0; a < 6; a++) op(1, 0, 16'(16'h0110 + a), 0);
    for (int a = 0; a < 4; a++) op(1, 0, 16'(16'h0120 + a), 0);
    idle(40);

    check("end_pending", exp_q.size(), 0);
    check("end_rd_cnt", rd_cnt, rd_exp);
    check("end_wr_cnt", wr_cnt, wr_exp);
    check("end_ovf", ovf_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
